// File: rtl/router_pkg.sv
// router_pkg: shared header layout, FSM encoding and LFSR taps for the router packet generator
package router_pkg;
  localparam int ADDR_W = 2;
  localparam int LEN_W = 6;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;
  localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PLD, S_PAR, S_GAP} state_e;
  function automatic logic [DATA_W-1:0] pack_hdr(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction
endpackage

// File: rtl/router_lfsr8.sv
// router_lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with enable and seed load
module router_lfsr8
  import router_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic       en,
  output logic [7:0] state_q
);
  logic [7:0] state_d;
  always_comb state_d = load ? SEED : en ? {state_q[6:0], ^(state_q & LFSR_TAPS)} : state_q;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state_q <= SEED;
    else state_q <= state_d;
endmodule

// File: rtl/router_pkt_gen.sv
// router_pkt_gen: turns a one-cycle command into header/payload/parity bytes for the 1x3 router
module router_pkt_gen
  import router_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  addr,
  input  logic [5:0]  len,
  input  logic        mode,
  input  logic        busy,
  output logic [7:0]  data_in,
  output logic        pkt_valid,
  output logic        ready,
  output logic        done,
  output logic        cmd_err,
  output logic [15:0] pkt_count
);
  state_e state_q, state_d;
  logic [7:0] data_q, data_d, par_q, par_d, lfsr_q, pld;
  logic [5:0] cnt_q, cnt_d, len_q, len_d;
  logic [3:0] gap_q, gap_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic valid_q, valid_d, mode_q, mode_d, done_q, done_d, err_q, err_d, lfsr_en;
  router_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock(clock), .resetn(resetn), .load(1'b0), .en(lfsr_en), .state_q(lfsr_q)
  );
  assign pld = mode_q ? {2'b00, cnt_q} : lfsr_q;
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    valid_d = valid_q;
    cnt_d = cnt_q;
    par_d = par_q;
    len_d = len_q;
    mode_d = mode_q;
    gap_d = gap_q;
    pkt_count_d = pkt_count_q;
    done_d = 1'b0;
    err_d = 1'b0;
    lfsr_en = 1'b0;
    case (state_q)
      S_IDLE:
        if (start && (addr == ADDR_ILLEGAL || len == '0)) err_d = 1'b1;
        else if (start) begin
          state_d = S_HDR;
          data_d = pack_hdr(len, addr);
          par_d = pack_hdr(len, addr);
          valid_d = 1'b1;
          cnt_d = '0;
          len_d = len;
          mode_d = mode;
        end
      S_HDR, S_PLD:
        if (!busy && cnt_q < len_q) begin
          state_d = S_PLD;
          data_d = pld;
          par_d = par_q ^ pld;
          cnt_d = cnt_q + 6'd1;
          lfsr_en = !mode_q;
        end else if (!busy) begin
          state_d = S_PAR;
          data_d = par_q;
          valid_d = 1'b0;
        end
      S_PAR:
        if (!busy) begin
          state_d = GAP_CYCLES == 0 ? S_IDLE : S_GAP;
          data_d = '0;
          done_d = 1'b1;
          pkt_count_d = pkt_count_q + 16'd1;
          gap_d = 4'(GAP_CYCLES);
        end
      S_GAP: begin
        state_d = gap_q <= 4'd1 ? S_IDLE : S_GAP;
        gap_d = gap_q <= 4'd1 ? 4'd0 : gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= S_IDLE;
      data_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
      par_q <= '0;
      len_q <= '0;
      mode_q <= 1'b0;
      gap_q <= '0;
      pkt_count_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      par_q <= par_d;
      len_q <= len_d;
      mode_q <= mode_d;
      gap_q <= gap_d;
      pkt_count_q <= pkt_count_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign data_in = data_q;
  assign pkt_valid = valid_q;
  assign ready = state_q == S_IDLE && gap_q == 4'd0;
  assign done = done_q;
  assign cmd_err = err_q;
  assign pkt_count = pkt_count_q;
endmodule

// File: tb/tb_router_pkt_gen.sv
// tb_router_pkt_gen: queue-based byte scoreboard plus directed literal checks for router_pkt_gen
module tb_router_pkt_gen;
  localparam int GAP = 2;
  typedef struct {logic [7:0] d; logic v;} byte_t;
  logic clock = 1'b0, resetn = 1'b0, start = 1'b0, mode = 1'b0, busy = 1'b0;
  logic [1:0] addr = '0;
  logic [5:0] len = '0;
  logic [7:0] data_in;
  logic pkt_valid, ready, done, cmd_err;
  logic [15:0] pkt_count;
  int checks = 0, errors = 0;
  byte_t exp_q[$];
  int m_gap = 0;
  logic m_done = 1'b0, m_err = 1'b0, m_rdy;
  logic [15:0] m_cnt = '0;
  logic [7:0] m_lfsr = 8'hA5, obs_x = '0;
  int obs_n = 0;

  router_pkt_gen #(.LFSR_SEED(8'hA5), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .resetn(resetn), .start(start), .addr(addr), .len(len), .mode(mode),
    .busy(busy), .data_in(data_in), .pkt_valid(pkt_valid), .ready(ready), .done(done),
    .cmd_err(cmd_err), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Model: a packet is the list of bytes it must emit; the front byte leaves on each unblocked edge
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      exp_q.delete();
      m_gap = 0;
      m_done = 1'b0;
      m_err = 1'b0;
      m_cnt = '0;
      m_lfsr = 8'hA5;
    end else begin
      m_rdy = exp_q.size() == 0 && m_gap == 0;
      m_done = 1'b0;
      m_err = 1'b0;
      if (exp_q.size() != 0) begin
        if (!busy) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_done = 1'b1;
            m_cnt++;
            m_gap = GAP;
          end
        end
      end else if (m_gap > 0) m_gap--;
      if (m_rdy && start) begin
        if (addr == 2'd3 || len == 6'd0) m_err = 1'b1;
        else begin
          logic [7:0] p, pb;
          p = {len, addr};
          exp_q.push_back('{p, 1'b1});
          for (int k = 0; k < int'(len); k++) begin
            pb = mode ? 8'(k) : m_lfsr;
            if (!mode) m_lfsr = lfsr_next(m_lfsr);
            p ^= pb;
            exp_q.push_back('{pb, 1'b1});
          end
          exp_q.push_back('{p, 1'b0});
        end
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      chk("data_in", {8'h0, data_in}, {8'h0, exp_q.size() != 0 ? exp_q[0].d : 8'h00});
      chk("pkt_valid", {15'h0, pkt_valid}, {15'h0, exp_q.size() != 0 ? exp_q[0].v : 1'b0});
      chk("ready", {15'h0, ready}, {15'h0, exp_q.size() == 0 && m_gap == 0});
      chk("done", {15'h0, done}, {15'h0, m_done});
      chk("cmd_err", {15'h0, cmd_err}, {15'h0, m_err});
      chk("pkt_count", pkt_count, m_cnt);
      if (pkt_valid && !busy) begin
        obs_x ^= data_in;
        obs_n++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [1:0] a, input logic [5:0] l, input logic m);
    int n = 0;
    while (!ready && n < 300) begin
      step();
      n++;
    end
    chk("send_ready", {15'h0, ready}, 16'h1);
    addr = a;
    len = l;
    mode = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output logic [7:0] par);
    int n = 0;
    logic [7:0] prev;
    do begin
      prev = data_in;
      step();
      n++;
    end while (!done && n < 300);
    chk("done_seen", {15'h0, done}, 16'h1);
    par = prev;
  endtask

  initial begin
    logic [7:0] p, hold;
    int n;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p, hold;
    int n;
    step();
    chk("rst_data", {8'h0, data_in}, 16'h0);
    chk("rst_valid", {15'h0, pkt_valid}, 16'h0);
    chk("rst_count", pkt_count, 16'h0);
    chk("rst_done", {15'h0, done}, 16'h0);
    resetn = 1'b1;
    step();
    chk("rst_ready", {15'h0, ready}, 16'h1);
    // incrementing payload, len 5 to port 0
    send(2'd0, 6'd5, 1'b1);
    chk("t1_hdr", {7'h0, pkt_valid, data_in}, 16'h114);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_pld", {7'h0, pkt_valid, data_in}, 16'(9'h100 + k));
    end
    step();
    chk("t1_par", {7'h0, pkt_valid, data_in}, 16'h010);
    step();
    chk("t1_done", {15'h0, done}, 16'h1);
    chk("t1_count", pkt_count, 16'h1);
    // len 14 to port 1, then the gap
    send(2'd1, 6'd14, 1'b1);
    chk("t2_hdr", {8'h0, data_in}, 16'h39);
    wait_done(p);
    chk("t2_par", {8'h0, p}, 16'h38);
    chk("t2_gap0", {15'h0, ready}, 16'h0);
    step();
    chk("t2_gap1", {15'h0, ready}, 16'h0);
    step();
    chk("t2_ready", {15'h0, ready}, 16'h1);
    // LFSR payload with back-pressure mid-payload and on parity
    obs_x = '0;
    obs_n = 0;
    send(2'd2, 6'd16, 1'b0);
    chk("t3_hdr", {8'h0, data_in}, 16'h42);
    step();
    chk("t3_first", {8'h0, data_in}, 16'hA5);
    repeat (3) step();
    busy = 1'b1;
    hold = data_in;
    repeat (3) begin
      step();
      chk("t3_hold", {7'h0, pkt_valid, data_in}, {7'h0, 1'b1, hold});
    end
    busy = 1'b0;
    n = 0;
    while (pkt_valid && n < 100) begin
      step();
      n++;
    end
    chk("t3_par", {8'h0, data_in}, {8'h0, obs_x});
    chk("t3_nbytes", 16'(obs_n), 16'd17);
    busy = 1'b1;
    hold = data_in;
    repeat (2) begin
      step();
      chk("t3_par_hold", {7'h0, done, data_in}, {8'h0, hold});
    end
    busy = 1'b0;
    step();
    chk("t3_done", {15'h0, done}, 16'h1);
    chk("t3_count", pkt_count, 16'h3);
    // illegal commands
    send(2'd3, 6'd4, 1'b0);
    chk("t4_err_addr", {14'h0, cmd_err, pkt_valid}, 16'h2);
    step();
    chk("t4_err_clr", {15'h0, cmd_err}, 16'h0);
    send(2'd1, 6'd0, 1'b1);
    chk("t4_err_len", {14'h0, cmd_err, pkt_valid}, 16'h2);
    step();
    chk("t4_count", pkt_count, 16'h3);
    // abort mid-packet
    send(2'd0, 6'd10, 1'b1);
    repeat (3) step();
    chk("t5_third", {8'h0, data_in}, 16'h02);
    resetn = 1'b0;
    #1;
    chk("t5_abort", {7'h0, pkt_valid, data_in}, 16'h0);
    chk("t5_count", pkt_count, 16'h0);
    step();
    step();
    resetn = 1'b1;
    chk("t5_ready", {15'h0, ready}, 16'h1);
    send(2'd2, 6'd3, 1'b0);
    step();
    chk("t5_seed", {8'h0, data_in}, 16'hA5);
    wait_done(p);
    // back-to-back with start held high
    n = 0;
    while (!ready && n < 50) begin
      step();
      n++;
    end
    addr = 2'd1;
    len = 6'd2;
    mode = 1'b0;
    start = 1'b1;
    step();
    chk("t6_hdr1", {8'h0, data_in}, 16'h09);
    step();
    chk("t6_pld1", {8'h0, data_in}, 16'h2A);
    wait_done(p);
    step();
    step();
    chk("t6_gap", {15'h0, pkt_valid}, 16'h0);
    step();
    chk("t6_hdr2", {7'h0, pkt_valid, data_in}, 16'h109);
    start = 1'b0;
    step();
    chk("t6_pld2", {8'h0, data_in}, 16'hA9);
    wait_done(p);
    chk("t6_count", pkt_count, 16'h3);
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
